// File: rtl/dsm_pkg.sv
// Shared constants, width helper and warm-up state encoding for the DSM
// bitstream receive path.
package dsm_pkg;

    localparam int OUT_W  = 16;
    localparam int WARMUP = 2;

    typedef enum logic [1:0] {
        WARM0 = 2'd0,
        WARM1 = 2'd1,
        RUN   = 2'd2
    } warm_state_t;

    // Register width that holds an order-N CIC gain of (2^osr_log2)^N exactly.
    function automatic int cic_width(input int order, input int osr_log2);
        return order * osr_log2 + 1;
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage: wrap-around accumulator with enable, exposing both
// the combinational next value (for same-cycle cascading) and the stored sum.
module cic_integrator #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] add_in,
    output logic [W-1:0] sum_next,
    output logic [W-1:0] sum
);

    logic [W-1:0] sum_reg;

    assign sum_next = sum_reg + add_in;
    assign sum      = sum_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_reg <= '0;
        end else if (en) begin
            sum_reg <= sum_next;
        end
    end

endmodule

// File: rtl/dsm_sinc3_decimator.sv
// Third-order CIC decimator: turns a unipolar 1-bit DSM stream into 16-bit
// unsigned samples, one per 2^OSR_LOG2 accepted bits, after a two-window warm-up.
module dsm_sinc3_decimator
    import dsm_pkg::*;
#(
    parameter int OSR_LOG2 = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid
);

    localparam int W     = cic_width(3, OSR_LOG2);
    localparam int SHIFT = 3 * OSR_LOG2 - OUT_W;

    logic [2:0][W-1:0] stage_in;
    logic [2:0][W-1:0] stage_next;
    logic [2:0][W-1:0] stage_sum_unused;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_int
            if (gi == 0) begin : g_first
                assign stage_in[gi] = {{(W-1){1'b0}}, bit_in};
            end else begin : g_rest
                assign stage_in[gi] = stage_next[gi-1];
            end

            cic_integrator #(
                .W(W)
            ) u_int (
                .clk      (clk),
                .reset    (reset),
                .en       (bit_valid),
                .add_in   (stage_in[gi]),
                .sum_next (stage_next[gi]),
                .sum      (stage_sum_unused[gi])
            );
        end
    endgenerate

    // Decimation counter; the window closes on the bit that sees it all-ones.
    logic [OSR_LOG2-1:0] cnt_reg;
    logic                dec_event;

    assign dec_event = bit_valid && (cnt_reg == {OSR_LOG2{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (bit_valid) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    logic [W-1:0] d1_reg, d2_reg, d3_reg;
    logic [W-1:0] c1, c2, y;

    assign c1 = stage_next[2] - d1_reg;
    assign c2 = c1 - d2_reg;
    assign y  = c2 - d3_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            d1_reg <= '0;
            d2_reg <= '0;
            d3_reg <= '0;
        end else if (dec_event) begin
            d1_reg <= stage_next[2];
            d2_reg <= c1;
            d3_reg <= c2;
        end
    end

    // Warm-up: the first two windows still hold pre-reset-zero history in the combs.
    warm_state_t state_reg, state_next;
    logic        load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= WARM0;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        if (dec_event) begin
            case (state_reg)
                WARM0:   state_next = WARM1;
                WARM1:   state_next = RUN;
                RUN: begin
                    state_next = RUN;
                    load       = 1'b1;
                end
                default: state_next = WARM0;
            endcase
        end
    end

    // y never exceeds OSR^3, so any bit above OUT_W after the shift means full scale.
    logic [W-1:0]     y_shift;
    logic             sat;
    logic [OUT_W-1:0] sample_next;

    assign y_shift     = y >> SHIFT;
    assign sat         = |y_shift[W-1:OUT_W];
    assign sample_next = sat ? {OUT_W{1'b1}} : y_shift[OUT_W-1:0];

    logic [OUT_W-1:0] sample_reg;
    logic             valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= load;
            if (load) begin
                sample_reg <= sample_next;
            end
        end
    end

    assign sample_out   = sample_reg;
    assign sample_valid = valid_reg;

endmodule

// File: tb/tb_dsm_sinc3_decimator.sv
// Scoreboard bench for dsm_sinc3_decimator: stimulus pushes expected strobes
// (value and clock edge), a negedge monitor pops and compares them.
module tb_dsm_sinc3_decimator;

    localparam int OSR_LOG2 = 6;
    localparam int OSR      = 1 << OSR_LOG2;
    localparam int FIRST    = 3 * OSR;

    logic        clk = 1'b0;
    logic        reset;
    logic        bit_in;
    logic        bit_valid;
    logic [15:0] sample_out;
    logic        sample_valid;

    always #5 clk = ~clk;

    dsm_sinc3_decimator #(
        .OSR_LOG2(OSR_LOG2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    typedef struct {
        logic [15:0] value;
        int          edge_no;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          edges    = 0;
    int          checks   = 0;
    int          fails    = 0;
    int          nacc     = 0;
    int          req_seq  = 0;
    int          done_seq = 0;
    int          strobes  = 0;
    logic [15:0] chk_val  = 16'h0000;

    always @(posedge clk) edges <= edges + 1;

    // Monitor: every strobe must match the head of the queue; idle checks are
    // requested by the stimulus through req_seq.
    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            checks++;
            strobes++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL strobe_unexpected: got sample_out=%h at edge %0d, required no strobe",
                         sample_out, edges);
            end else begin
                mon_e = exp_q.pop_front();
                if (sample_out !== mon_e.value || edges != mon_e.edge_no) begin
                    fails++;
                    $display("FAIL strobe_value: got %h at edge %0d, required %h at edge %0d",
                             sample_out, edges, mon_e.value, mon_e.edge_no);
                end else begin
                    $display("strobe %0d: sample_out=%h at edge %0d ok", strobes, sample_out, edges);
                end
            end
        end
        if (req_seq != done_seq) begin
            checks++;
            if (sample_out !== chk_val || sample_valid !== 1'b0 || exp_q.size() != 0) begin
                fails++;
                $display("FAIL idle_state: got sample_out=%h valid=%b pending=%0d, required sample_out=%h valid=0 pending=0",
                         sample_out, sample_valid, exp_q.size(), chk_val);
            end else begin
                $display("idle check: sample_out=%h ok", sample_out);
            end
            done_seq = req_seq;
        end
    end

    task automatic drive(input logic b, input logic v, input logic [15:0] expv);
        bit_in    = b;
        bit_valid = v;
        if (v && !reset) begin
            nacc++;
            if (nacc >= FIRST && (nacc % OSR) == 0) begin
                exp_q.push_back('{expv, edges + 1});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic request_check(input logic [15:0] v);
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        chk_val   = v;
        req_seq++;
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge while a valid bit is presented: reset must win.
    task automatic do_reset(input logic b, input logic v);
        reset     = 1'b1;
        bit_in    = b;
        bit_valid = v;
        @(posedge clk);
        #1;
        reset = 1'b0;
        nacc  = 0;
    endtask

    task automatic run_pattern(input logic [3:0] pat, input int plen, input int nbits,
                               input logic [15:0] expv);
        for (int i = 0; i < nbits; i++) begin
            drive(pat[i % plen], 1'b1, expv);
        end
    endtask

    initial begin
        reset     = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        request_check(16'h0000);
        reset = 1'b0;
        request_check(16'h0000);

        // All ones: first strobe after bit 192, then every 64 bits, full scale.
        run_pattern(4'b1111, 1, FIRST + 3 * OSR, 16'hFFFF);
        idle(2);
        request_check(16'hFFFF);
        do_reset(1'b0, 1'b0);
        request_check(16'h0000);

        run_pattern(4'b0000, 1, FIRST + 2 * OSR, 16'h0000);
        idle(2);
        request_check(16'h0000);
        do_reset(1'b0, 1'b0);

        // pat[0] is the first bit sent: 1,0,1,0 and 1,0,0,0.
        run_pattern(4'b0101, 2, FIRST + 2 * OSR, 16'h8000);
        idle(2);
        request_check(16'h8000);
        do_reset(1'b0, 1'b0);

        run_pattern(4'b0001, 4, FIRST + 2 * OSR, 16'h4000);
        idle(2);
        request_check(16'h4000);
        do_reset(1'b0, 1'b0);

        // Valid every third cycle; invalid cycles carry a mix of 0 and 1.
        for (int i = 0; i < FIRST + OSR; i++) begin
            drive(1'b1, 1'b1, 16'hFFFF);
            drive(1'b0, 1'b0, 16'hFFFF);
            drive(1'b1, 1'b0, 16'hFFFF);
        end
        idle(2);
        request_check(16'hFFFF);
        do_reset(1'b0, 1'b0);

        // Reset on the edge that would consume bit 192: no strobe may appear.
        run_pattern(4'b1111, 1, FIRST - 1, 16'hFFFF);
        do_reset(1'b1, 1'b1);
        idle(2);
        request_check(16'h0000);

        // Reset after 150 ones, then zeros: no residue in the first sample.
        run_pattern(4'b1111, 1, 150, 16'hFFFF);
        do_reset(1'b1, 1'b1);
        run_pattern(4'b0000, 1, FIRST + OSR, 16'h0000);
        idle(2);
        request_check(16'h0000);
        do_reset(1'b0, 1'b0);

        // Long all-ones run: integrators wrap repeatedly, output stays full scale.
        run_pattern(4'b1111, 1, 1344, 16'hFFFF);
        idle(2);
        request_check(16'hFFFF);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dsm_sinc3_decimator.md
# dsm_sinc3_decimator

Third-order CIC (sinc³) decimation filter that reconstructs 16-bit unsigned samples from the 1-bit stream produced by the team's second-order delta-sigma modulator. It sits at the receiving end of the DSM bitstream link. It converts ones-density into a sample value scaled so that density d maps to d·2^16 (saturated to 0xFFFF). It emits one sample per OSR accepted bits, with a one-cycle valid strobe.

## Interface
Parameters:
- OSR_LOG2, default 6: log2 of the decimation ratio OSR; legal range 6..10.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- bit_in  input  1  DSM bitstream bit; 1 = +1, 0 = 0 (unipolar).
- bit_valid  input  1  bit_in is consumed on a rising edge only when high.
- sample_out  output  16  decimated unsigned sample; holds between strobes.
- sample_valid  output  1  one-cycle strobe, high when sample_out is new.

## Operation
- Internal width W = 3·OSR_LOG2 + 1.
  - All integrator, comb and delay registers are W bits, unsigned, with modular (wrap-around) arithmetic.
  - Wrap is intentional. The comb differences are exact mod 2^W because the filter gain OSR³ < 2^W.
- Integrators update only on bit_valid cycles and are cascaded within the same cycle:
  - i1n = i1 + bit_in
  - i2n = i2 + i1n
  - i3n = i3 + i2n
  - Registers take i1n, i2n, i3n.
- Decimation counter cnt counts 0..OSR-1 and advances only on bit_valid cycles.
  - A decimation event is a bit_valid cycle with cnt = OSR-1. On that event cnt wraps to 0.
- On a decimation event the combs are evaluated combinationally from i3n:
  - c1 = i3n - d1
  - c2 = c1 - d2
  - y = c2 - d3
  - Delay registers update: d1 <= i3n, d2 <= c1, d3 <= c2.
- Scaling: sample_out <= y >> (3·OSR_LOG2 - 16). If y = OSR³ (all ones), sample_out <= 0xFFFF.
- Warm-up counter wu (2 bits) counts the first 2 decimation events after reset.
  - While wu < 2: the combs and delays still update, but sample_out and sample_valid stay unchanged.
  - From the third event on, every event loads sample_out and strobes sample_valid.
- States (warm-up tracking): WARM0 -> WARM1 -> RUN, advancing on decimation events only. RUN is absorbing until reset.
- With bit_valid low: all state holds and sample_valid is 0.

## Timing
- Reset values:
  - sample_out = 0x0000, sample_valid = 0.
  - cnt = 0, wu = 0 (WARM0).
  - All integrators, combs and delays = 0.
- Latency: sample_valid is high in the cycle immediately after the clock edge that consumed the OSR-th bit of a decimation window. Exactly one cycle wide.
- First emitted sample: after 3·OSR accepted bits from reset. It covers a full sinc³ window of post-reset data, so no transient appears in emitted samples.
- Back-to-back valid bits: strobes are exactly OSR cycles apart. Gaps in bit_valid stretch the spacing but never change sample values.
- Reset asserted mid-window or mid-warm-up takes priority over bit_valid.
  - Everything clears on that edge and any pending strobe is dropped.
  - After release, warm-up restarts from WARM0.
- The same cycle cannot both reset and strobe: reset forces sample_valid to 0.

## Structure
- Package dsm_pkg holds:
  - OUT_W = 16 and WARMUP = 2.
  - A constant function cic_width(order, osr_log2) returning order·osr_log2 + 1.
  - The warm-up state enum (WARM0, WARM1, RUN).
- One sub-module is natural: cic_integrator.
  - Parameterised width, enable, add-in, combinational next-value output, and registered value.
  - Instantiated three times in cascade.
  - Combs, counter, warm-up FSM and scaling live in the top.

## Test plan
- All-ones input, bit_valid held high, OSR_LOG2 = 6 -> no strobe for cycles 1..191. First strobe one cycle after bit 192 with sample_out = 0xFFFF. Every 64 cycles thereafter, 0xFFFF.
- All-zeros input -> first strobe after bit 192 with sample_out = 0x0000; sample_out stays 0x0000 on every strobe.
- Alternating 1,0,1,0 -> every emitted sample = 0x8000. Pattern 1,0,0,0 repeating -> every emitted sample = 0x4000.
- All-ones with bit_valid high every third cycle -> same 0xFFFF values, strobes exactly 192 cycles apart, sample_valid never high for more than one cycle.
- Reset pulsed after 150 bits of all-ones, then all-zeros -> no strobe before 192 post-reset bits. First strobe = 0x0000, showing no residue from pre-reset state.
- Free-running all-ones for 2^W+ bits with OSR_LOG2 = 10 -> integrators wrap and sample_out remains 0xFFFF on every strobe.
